// File: rtl/serial_uart_tx.sv
// Byte FIFO plus 8N1 UART transmitter fed from the processor serial port.
// Frames leave back to back while bytes are queued, with no idle gap.
module serial_uart_tx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_ADDR_W  = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [7:0]           serial_in,
  input  logic                 serial_wren_in,
  output logic                 serial_ready_out,
  output logic                 tx_out,
  output logic                 busy_out,
  output logic [FIFO_ADDR_W:0] fifo_count_out,
  output logic                 overflow_out
);

  localparam int DEPTH  = 2 ** FIFO_ADDR_W;
  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int CNT_W  = FIFO_ADDR_W + 1;

  localparam logic [BAUD_W-1:0] BAUD_MAX = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  FULL     = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t                 state_q, state_d;
  logic [BAUD_W-1:0]      baud_q, baud_d;
  logic [2:0]             bit_q, bit_d;
  logic [7:0]             shift_q, shift_d;
  logic                   tx_q, tx_d;
  logic                   ovf_q, ovf_d;
  logic [FIFO_ADDR_W-1:0] wr_q, wr_d;
  logic [FIFO_ADDR_W-1:0] rd_q, rd_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [7:0]             mem_q [DEPTH];

  logic full;
  logic empty;
  logic push;
  logic pop;
  logic bit_end;

  always_comb begin
    full    = (cnt_q == FULL);
    empty   = (cnt_q == '0);
    push    = serial_wren_in && !full;
    bit_end = (baud_q == BAUD_MAX);
    pop     = !empty &&
              ((state_q == IDLE) ||
               ((state_q == STOP) && bit_end));

    state_d = state_q;
    baud_d  = bit_end ? '0 : baud_q + BAUD_W'(1);
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;

    unique case (state_q)
      IDLE: begin
        baud_d = '0;
        tx_d   = 1'b1;
        if (pop) begin
          state_d = START;
          tx_d    = 1'b0;
          shift_d = mem_q[rd_q];
        end
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          tx_d    = shift_q[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_q == 3'd7) begin
            state_d = STOP;
            bit_d   = '0;
            tx_d    = 1'b1;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
          end
        end
      end
      STOP: begin
        if (bit_end) begin
          if (pop) begin
            state_d = START;
            tx_d    = 1'b0;
            shift_d = mem_q[rd_q];
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // A push while full is lost even if a pop frees a slot this cycle.
    wr_d  = push ? wr_q + FIFO_ADDR_W'(1) : wr_q;
    rd_d  = pop ? rd_q + FIFO_ADDR_W'(1) : rd_q;
    cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop);
    ovf_d = ovf_q | (serial_wren_in & full);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      ovf_q   <= 1'b0;
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      ovf_q   <= ovf_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push) begin
      mem_q[wr_q] <= serial_in;
    end
  end

  assign serial_ready_out = !full;
  assign tx_out           = tx_q;
  assign busy_out         = (state_q != IDLE) || !empty;
  assign fifo_count_out   = cnt_q;
  assign overflow_out     = ovf_q;

endmodule

// File: tb/tb_serial_uart_tx.sv
// Bench for serial_uart_tx: frame decoder scoreboard on a 4-clock-per-bit
// instance, raw bitstream scoreboard on a 1-clock-per-bit instance.
module tb_serial_uart_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [7:0] din4, din1;
  logic       wr4, wr1;
  logic       rdy4, tx4, busy4, ovf4;
  logic       rdy1, tx1, busy1, ovf1;
  logic [4:0] cnt4, cnt1;

  serial_uart_tx #(
    .CLKS_PER_BIT(4),
    .FIFO_ADDR_W (4)
  ) dut4 (
    .clock           (clk),
    .reset           (rst_n),
    .serial_in       (din4),
    .serial_wren_in  (wr4),
    .serial_ready_out(rdy4),
    .tx_out          (tx4),
    .busy_out        (busy4),
    .fifo_count_out  (cnt4),
    .overflow_out    (ovf4)
  );

  serial_uart_tx #(
    .CLKS_PER_BIT(1),
    .FIFO_ADDR_W (4)
  ) dut1 (
    .clock           (clk),
    .reset           (rst_n),
    .serial_in       (din1),
    .serial_wren_in  (wr1),
    .serial_ready_out(rdy1),
    .tx_out          (tx1),
    .busy_out        (busy1),
    .fifo_count_out  (cnt1),
    .overflow_out    (ovf1)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] exp_q [$];
  logic       bitq  [$];
  int         starts[$];
  bit         mon_en;
  int         mon_s;
  logic [7:0] mon_b;
  logic [7:0] mon_e;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // negedge after posedge number c
  task automatic at_cyc(input int c);
    do @(negedge clk); while (cyc < c);
  endtask

  task automatic push4(input logic [7:0] b, input bit accept);
    din4 = b;
    wr4  = 1'b1;
    if (accept) exp_q.push_back(b);
    @(posedge clk);
    #1 wr4 = 1'b0;
  endtask

  task automatic push1(input logic [7:0] b);
    din1 = b;
    wr1  = 1'b1;
    bitq.push_back(1'b0);
    for (int i = 0; i < 8; i++) bitq.push_back(b[i]);
    bitq.push_back(1'b1);
    @(posedge clk);
    #1 wr1 = 1'b0;
  endtask

  task automatic wait_idle4(input int bound);
    int n;
    n = 0;
    while ((busy4 !== 1'b0) && (n < bound)) begin
      @(negedge clk);
      n++;
    end
    check("idle4_timeout", n < bound, 1);
  endtask

  // Decode 8N1 frames on tx4, sampling mid-bit.
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en && rst_n && tx4 === 1'b0) begin
        mon_s = cyc;
        repeat (2) @(negedge clk);
        check("start_bit", tx4, 0);
        for (int i = 0; i < 8; i++) begin
          repeat (4) @(negedge clk);
          mon_b[i] = tx4;
        end
        repeat (4) @(negedge clk);
        check("stop_bit", tx4, 1);
        check("frame_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          mon_e = exp_q.pop_front();
          check("frame_byte", mon_b, mon_e);
        end
        starts.push_back(mon_s);
        @(negedge clk);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int k;
    int s;
    rst_n  = 1'b0;
    wr4    = 1'b0;
    wr1    = 1'b0;
    din4   = '0;
    din1   = '0;
    mon_en = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_tx4", tx4, 1);
    check("rst_busy4", busy4, 0);
    check("rst_cnt4", cnt4, 0);
    check("rst_ovf4", ovf4, 0);
    check("rst_rdy4", rdy4, 1);
    check("rst_tx1", tx1, 1);
    check("rst_busy1", busy1, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // T1 single byte, latency and frame length
    push4(8'h55, 1);
    k = cyc;
    at_cyc(k);
    check("t1_tx_before", tx4, 1);
    check("t1_cnt", cnt4, 1);
    at_cyc(k + 1);
    check("t1_tx_low", tx4, 0);
    check("t1_cnt_popped", cnt4, 0);
    at_cyc(k + 40);
    check("t1_busy_last", busy4, 1);
    at_cyc(k + 41);
    check("t1_busy_done", busy4, 0);
    check("t1_tx_idle", tx4, 1);
    check("t1_frames", starts.size(), 1);
    s = starts.pop_front();
    check("t1_start_cyc", s, k + 1);

    // T2 two contiguous frames
    push4(8'hA5, 1);
    push4(8'h3C, 1);
    k = cyc;
    wait_idle4(300);
    check("t2_frames", starts.size(), 2);
    s = starts.pop_front();
    check("t2_start1", s, k);
    s = starts.pop_front();
    check("t2_start2", s, k + 40);
    check("t2_sb_empty", exp_q.size(), 0);

    // Fill: one byte in flight plus 16 queued
    for (int i = 0; i < 17; i++) push4(8'h10 + 8'(i), 1);
    k = cyc;
    at_cyc(k);
    check("fill_cnt", cnt4, 16);
    check("fill_rdy", rdy4, 0);
    check("fill_ovf", ovf4, 0);
    // Push lands on the same edge as the stop-end pop
    at_cyc(k + 24);
    check("t4_cnt_pre", cnt4, 16);
    din4 = 8'hEE;
    wr4  = 1'b1;
    @(posedge clk);
    #1 wr4 = 1'b0;
    at_cyc(k + 25);
    check("t4_cnt", cnt4, 15);
    check("t4_ovf", ovf4, 1);
    check("t4_rdy", rdy4, 1);
    push4(8'h77, 1);
    push4(8'h88, 0);
    at_cyc(cyc);
    check("t3_cnt", cnt4, 16);
    check("t3_rdy", rdy4, 0);
    check("t3_ovf", ovf4, 1);
    wait_idle4(2000);
    check("t3_ovf_sticky", ovf4, 1);
    check("t3_frames", starts.size(), 18);
    check("t3_sb_empty", exp_q.size(), 0);
    starts.delete();

    // T5 reset mid-frame during data bit 3
    mon_en = 1'b0;
    push4(8'hF0, 0);
    push4(8'h11, 0);
    k = cyc;
    at_cyc(k + 17);
    check("t5_bit3", tx4, 0);
    check("t5_cnt_pre", cnt4, 1);
    rst_n = 1'b0;
    at_cyc(k + 18);
    check("t5_tx", tx4, 1);
    check("t5_cnt", cnt4, 0);
    check("t5_busy", busy4, 0);
    check("t5_ovf", ovf4, 0);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);
    push4(8'h81, 1);
    wait_idle4(300);
    check("t5_frames", starts.size(), 1);
    check("t5_sb_empty", exp_q.size(), 0);

    // T6 one clock per bit, raw bitstream
    @(negedge clk);
    push1(8'hFF);
    push1(8'h00);
    k = cyc;
    for (int i = 0; i < 20; i++) begin
      at_cyc(k + i);
      check($sformatf("t6_bit%0d", i), tx1, bitq.pop_front());
    end
    at_cyc(k + 20);
    check("t6_busy", busy1, 0);
    check("t6_tx_idle", tx1, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
